// File: rtl/breg_cycle_ctl.sv
// -----------------------------------------------------------------------------
// breg_cycle_ctl
//
// Bus-cycle sequencer and arbiter in front of the board register decoder.
// A level-sensitive bus select is turned into a one-cycle settle phase, a
// wait-stated register strobe and then DTACK (or BERR when the decoder does
// not claim the address). The decoder is shared with the internal CREG serial
// engine using round-robin arbitration. Every output is registered.
//
// Ports:
//   CCLK         in   clock
//   RESET_n      in   synchronous reset, active low
//   SBSELECT     in   bus cycle select, level, high for the whole cycle
//   SBREAD_n     in   bus direction (0 = read), sampled in SETTLE
//   A[8:0]       in   address bits [10:2], sampled in SETTLE
//   DTACK_REQ_n  in   decoder: 0 = address decoded
//   CREG_REQ     in   CREG engine request, level
//   CREG_GNT     out  grant to CREG engine
//   STRB_n       out  decoder strobe qualifier, active low
//   RD_LATCH     out  one-cycle read-data latch pulse
//   DTACK_n      out  bus acknowledge, active low
//   BERR_n       out  bus error, active low
//   TMO          out  sticky timeout flag, cleared only by reset
//   BUSY         out  sequencer not idle
// -----------------------------------------------------------------------------
module breg_cycle_ctl #(
    parameter int unsigned WS_REG  = 2,   // strobe cycles, ordinary registers (1..15)
    parameter int unsigned WS_FIFO = 4,   // strobe cycles, FIFO registers (1..15)
    parameter int unsigned TIMEOUT = 200  // max hold cycles in ACK/ERR/GRANT (1..255)
) (
    input  logic       CCLK,
    input  logic       RESET_n,
    input  logic       SBSELECT,
    input  logic       SBREAD_n,
    input  logic [8:0] A,
    input  logic       DTACK_REQ_n,
    input  logic       CREG_REQ,
    output logic       CREG_GNT,
    output logic       STRB_n,
    output logic       RD_LATCH,
    output logic       DTACK_n,
    output logic       BERR_n,
    output logic       TMO,
    output logic       BUSY
);

    typedef enum logic [2:0] {
        StIdle,
        StSettle,
        StStrb,
        StAck,
        StErr,
        StGrant
    } state_t;

    localparam logic [3:0] WsReg   = 4'(WS_REG);
    localparam logic [3:0] WsFifo  = 4'(WS_FIFO);
    localparam logic [7:0] TmoLast = 8'(TIMEOUT - 1);

    state_t     r_state, w_state_d;
    logic [3:0] r_ws_cnt, w_ws_cnt_d;    // strobe cycles remaining, including current
    logic [7:0] r_tmo_cnt, w_tmo_cnt_d;  // cycles already spent in ACK/ERR/GRANT
    logic       r_rd, w_rd_d;
    logic       r_last_creg, w_last_creg_d;
    logic       r_rearm, w_rearm_d;      // bus select has been seen low since last timeout
    logic       r_tmo, w_tmo_d;

    logic       w_strb_n_d, w_rd_latch_d, w_dtack_n_d, w_berr_n_d, w_gnt_d, w_busy_d;
    logic       r_strb_n, r_rd_latch, r_dtack_n, r_berr_n, r_gnt, r_busy;

    logic       w_bus_req;
    logic       w_tmo_hit;
    logic       w_fifo;
    logic       w_unused_a;

    assign w_bus_req  = SBSELECT & r_rearm;
    assign w_tmo_hit  = (r_tmo_cnt == TmoLast);
    assign w_fifo     = (A[6:4] == 3'b111);
    assign w_unused_a = ^{A[8:7], A[3:0]};

    // State and registered outputs.
    always_ff @(posedge CCLK) begin
        if (!RESET_n) begin
            r_state     <= StIdle;
            r_ws_cnt    <= 4'd0;
            r_tmo_cnt   <= 8'd0;
            r_rd        <= 1'b0;
            r_last_creg <= 1'b1;
            r_rearm     <= 1'b1;
            r_tmo       <= 1'b0;
            r_strb_n    <= 1'b1;
            r_rd_latch  <= 1'b0;
            r_dtack_n   <= 1'b1;
            r_berr_n    <= 1'b1;
            r_gnt       <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_ws_cnt    <= w_ws_cnt_d;
            r_tmo_cnt   <= w_tmo_cnt_d;
            r_rd        <= w_rd_d;
            r_last_creg <= w_last_creg_d;
            r_rearm     <= w_rearm_d;
            r_tmo       <= w_tmo_d;
            r_strb_n    <= w_strb_n_d;
            r_rd_latch  <= w_rd_latch_d;
            r_dtack_n   <= w_dtack_n_d;
            r_berr_n    <= w_berr_n_d;
            r_gnt       <= w_gnt_d;
            r_busy      <= w_busy_d;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_d     = r_state;
        w_ws_cnt_d    = r_ws_cnt;
        w_tmo_cnt_d   = r_tmo_cnt;
        w_rd_d        = r_rd;
        w_last_creg_d = r_last_creg;
        w_tmo_d       = r_tmo;
        w_rearm_d     = r_rearm | ~SBSELECT;

        unique case (r_state)
            StIdle: begin
                // On a tie the requester that did not win last time goes.
                if (w_bus_req && (!CREG_REQ || r_last_creg)) begin
                    w_state_d     = StSettle;
                    w_last_creg_d = 1'b0;
                end else if (CREG_REQ) begin
                    w_state_d     = StGrant;
                    w_last_creg_d = 1'b1;
                    w_tmo_cnt_d   = 8'd0;
                end
            end
            StSettle: begin
                if (!SBSELECT) begin
                    w_state_d = StIdle;
                end else begin
                    w_rd_d     = ~SBREAD_n;
                    w_ws_cnt_d = w_fifo ? WsFifo : WsReg;
                    if (!DTACK_REQ_n) begin
                        w_state_d = StStrb;
                    end else begin
                        w_state_d   = StErr;
                        w_tmo_cnt_d = 8'd0;
                    end
                end
            end
            StStrb: begin
                if (!SBSELECT) begin
                    w_state_d = StIdle;
                end else if (r_ws_cnt == 4'd1) begin
                    w_state_d   = StAck;
                    w_tmo_cnt_d = 8'd0;
                end else begin
                    w_ws_cnt_d = r_ws_cnt - 4'd1;
                end
            end
            StAck, StErr: begin
                if (!SBSELECT) begin
                    w_state_d = StIdle;
                end else if (w_tmo_hit) begin
                    // Select still high: ignore it until it has been seen low.
                    w_state_d = StIdle;
                    w_tmo_d   = 1'b1;
                    w_rearm_d = 1'b0;
                end else begin
                    w_tmo_cnt_d = r_tmo_cnt + 8'd1;
                end
            end
            StGrant: begin
                if (!CREG_REQ) begin
                    w_state_d = StIdle;
                end else if (w_tmo_hit) begin
                    w_state_d = StIdle;
                    w_tmo_d   = 1'b1;
                end else begin
                    w_tmo_cnt_d = r_tmo_cnt + 8'd1;
                end
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    // Output decode from the next state, so every output comes straight off a flop.
    always_comb begin
        w_strb_n_d   = (w_state_d != StStrb);
        w_rd_latch_d = (w_state_d == StStrb) && (w_ws_cnt_d == 4'd1) && w_rd_d;
        w_dtack_n_d  = (w_state_d != StAck);
        w_berr_n_d   = (w_state_d != StErr);
        w_gnt_d      = (w_state_d == StGrant);
        w_busy_d     = (w_state_d != StIdle);
    end

    assign STRB_n   = r_strb_n;
    assign RD_LATCH = r_rd_latch;
    assign DTACK_n  = r_dtack_n;
    assign BERR_n   = r_berr_n;
    assign CREG_GNT = r_gnt;
    assign BUSY     = r_busy;
    assign TMO      = r_tmo;

endmodule

// File: tb/tb_breg_cycle_ctl.sv
// -----------------------------------------------------------------------------
// tb_breg_cycle_ctl
//
// Directed bench for breg_cycle_ctl. A cycle-level model expresses a bus
// transaction as an "age" (cycles since the accepting edge) and derives the
// outputs from it; a compare process checks every DUT output against it on
// every falling edge. Directed scenarios add hand-computed literal checks.
// -----------------------------------------------------------------------------
module tb_breg_cycle_ctl;

    localparam int unsigned WS_REG  = 2;
    localparam int unsigned WS_FIFO = 4;
    localparam int unsigned TIMEOUT = 200;

    logic       CCLK = 1'b0;
    logic       RESET_n = 1'b0;
    logic       SBSELECT = 1'b0;
    logic       SBREAD_n = 1'b1;
    logic [8:0] A = 9'h000;
    logic       DTACK_REQ_n = 1'b1;
    logic       CREG_REQ = 1'b0;
    logic       CREG_GNT, STRB_n, RD_LATCH, DTACK_n, BERR_n, TMO, BUSY;

    int checks = 0;
    int errors = 0;

    always #5 CCLK = ~CCLK;

    breg_cycle_ctl #(
        .WS_REG  (WS_REG),
        .WS_FIFO (WS_FIFO),
        .TIMEOUT (TIMEOUT)
    ) u_dut (
        .CCLK        (CCLK),
        .RESET_n     (RESET_n),
        .SBSELECT    (SBSELECT),
        .SBREAD_n    (SBREAD_n),
        .A           (A),
        .DTACK_REQ_n (DTACK_REQ_n),
        .CREG_REQ    (CREG_REQ),
        .CREG_GNT    (CREG_GNT),
        .STRB_n      (STRB_n),
        .RD_LATCH    (RD_LATCH),
        .DTACK_n     (DTACK_n),
        .BERR_n      (BERR_n),
        .TMO         (TMO),
        .BUSY        (BUSY)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Model: mode 0 idle, 1 bus transaction, 2 CREG grant.
    // Bus: age 0 = settle, ages 1..ws = strobe (decoded), later = ack/err.
    // ------------------------------------------------------------------
    int m_mode = 0;
    int m_age = 0;
    int m_ws = 0;
    bit m_rd = 0;
    bit m_dec = 0;
    bit m_last_creg = 1;
    bit m_rearm = 1;
    bit m_tmo = 0;

    task automatic model_step();
        int hold;
        if (!RESET_n) begin
            m_mode = 0; m_age = 0; m_last_creg = 1; m_rearm = 1; m_tmo = 0;
        end else begin
            case (m_mode)
                0: begin
                    if (SBSELECT && m_rearm && (!CREG_REQ || m_last_creg)) begin
                        m_mode = 1; m_age = 0; m_last_creg = 0;
                    end else if (CREG_REQ) begin
                        m_mode = 2; m_age = 0; m_last_creg = 1;
                    end
                end
                1: begin
                    if (!SBSELECT) begin
                        m_mode = 0;
                    end else if (m_age == 0) begin
                        m_rd  = !SBREAD_n;
                        m_dec = !DTACK_REQ_n;
                        m_ws  = (A[6:4] == 3'b111) ? WS_FIFO : WS_REG;
                        m_age = 1;
                    end else if (m_dec && m_age <= m_ws) begin
                        m_age++;
                    end else begin
                        hold = m_age - (m_dec ? m_ws + 1 : 1);
                        if (hold == TIMEOUT - 1) begin
                            m_mode = 0; m_tmo = 1; m_rearm = 0;
                        end else begin
                            m_age++;
                        end
                    end
                end
                default: begin
                    if (!CREG_REQ) m_mode = 0;
                    else if (m_age == TIMEOUT - 1) begin m_mode = 0; m_tmo = 1; end
                    else m_age++;
                end
            endcase
            if (!SBSELECT) m_rearm = 1;
        end
    endtask

    always @(posedge CCLK) model_step();

    always @(negedge CCLK) begin
        bit bus;
        bus = (m_mode == 1) && (m_age >= 1);
        chk("STRB_n",   STRB_n,   !(bus && m_dec && m_age <= m_ws));
        chk("RD_LATCH", RD_LATCH, bus && m_dec && m_rd && m_age == m_ws);
        chk("DTACK_n",  DTACK_n,  !(bus && m_dec && m_age > m_ws));
        chk("BERR_n",   BERR_n,   !(bus && !m_dec));
        chk("CREG_GNT", CREG_GNT, m_mode == 2);
        chk("BUSY",     BUSY,     m_mode != 0);
        chk("TMO",      TMO,      m_tmo);
    end

    // ------------------------------------------------------------------
    // Directed stimulus helpers. Cycle c = c-th falling edge after the
    // select was raised.
    // ------------------------------------------------------------------
    int s_strb_first, s_strb_cnt, s_rdl_first, s_rdl_cnt;
    int s_dtack_first, s_dtack_last, s_dtack_cnt, s_berr_first, s_berr_cnt;
    int s_gnt_first, s_busy_cnt;

    task automatic step();
        @(negedge CCLK);
        #1;
    endtask

    task automatic clear_stats();
        s_strb_first = -1; s_strb_cnt = 0; s_rdl_first = -1; s_rdl_cnt = 0;
        s_dtack_first = -1; s_dtack_last = -1; s_dtack_cnt = 0;
        s_berr_first = -1; s_berr_cnt = 0; s_gnt_first = -1; s_busy_cnt = 0;
    endtask

    task automatic observe(input int c);
        if (!STRB_n) begin if (s_strb_first < 0) s_strb_first = c; s_strb_cnt++; end
        if (RD_LATCH) begin if (s_rdl_first < 0) s_rdl_first = c; s_rdl_cnt++; end
        if (!DTACK_n) begin
            if (s_dtack_first < 0) s_dtack_first = c;
            s_dtack_last = c; s_dtack_cnt++;
        end
        if (!BERR_n) begin if (s_berr_first < 0) s_berr_first = c; s_berr_cnt++; end
        if (CREG_GNT && s_gnt_first < 0) s_gnt_first = c;
        if (BUSY) s_busy_cnt++;
    endtask

    task automatic run_bus(input logic [8:0] addr, input bit rd, input bit dec,
                           input int hold, input int tail);
        A = addr; SBREAD_n = !rd; DTACK_REQ_n = !dec; SBSELECT = 1'b1;
        clear_stats();
        for (int c = 1; c <= hold + tail; c++) begin
            step();
            observe(c);
            if (c == hold) SBSELECT = 1'b0;
        end
    endtask

    task automatic do_reset();
        RESET_n = 1'b0; SBSELECT = 1'b0; CREG_REQ = 1'b0;
        step(); step();
        RESET_n = 1'b1;
        step();
    endtask

    initial begin
        int order[$];
        bit prev_d, prev_g;
        int gnt_cnt, gnt_gap;

        do_reset();
        chk("rst STRB_n", STRB_n, 1);
        chk("rst DTACK_n", DTACK_n, 1);
        chk("rst BERR_n", BERR_n, 1);
        chk("rst RD_LATCH", RD_LATCH, 0);
        chk("rst CREG_GNT", CREG_GNT, 0);
        chk("rst TMO", TMO, 0);
        chk("rst BUSY", BUSY, 0);

        // Write to reg 5.
        run_bus(9'h005, 0, 1, 10, 3);
        chk("wr strb_first", s_strb_first, 2);
        chk("wr strb_cnt", s_strb_cnt, 2);
        chk("wr dtack_first", s_dtack_first, 4);
        chk("wr dtack_last", s_dtack_last, 10);
        chk("wr rdl_cnt", s_rdl_cnt, 0);
        chk("wr berr_cnt", s_berr_cnt, 0);

        // FIFO read.
        run_bus(9'h070, 1, 1, 10, 3);
        chk("fifo strb_first", s_strb_first, 2);
        chk("fifo strb_cnt", s_strb_cnt, 4);
        chk("fifo rdl_cnt", s_rdl_cnt, 1);
        chk("fifo rdl_first", s_rdl_first, 5);
        chk("fifo dtack_first", s_dtack_first, 6);

        // FIFO write, other address bits set.
        run_bus(9'h17C, 0, 1, 8, 2);
        chk("fifo wr strb_cnt", s_strb_cnt, 4);
        chk("fifo wr rdl_cnt", s_rdl_cnt, 0);

        // Undecoded address.
        run_bus(9'h012, 1, 0, 6, 3);
        chk("err berr_first", s_berr_first, 2);
        chk("err berr_cnt", s_berr_cnt, 5);
        chk("err strb_cnt", s_strb_cnt, 0);
        chk("err dtack_cnt", s_dtack_cnt, 0);

        // Simultaneous requests after reset: bus wins, CREG next.
        do_reset();
        CREG_REQ = 1'b1;
        run_bus(9'h005, 0, 1, 6, 4);
        chk("arb dtack_last", s_dtack_last, 6);
        chk("arb strb_first", s_strb_first, 2);
        chk("arb gnt_first", s_gnt_first, 8);

        // Both requesters held and re-raised after each service: alternate.
        SBSELECT = 1'b1;
        prev_d = DTACK_n;
        prev_g = CREG_GNT;
        for (int c = 0; c < 80 && order.size() < 6; c++) begin
            step();
            if (!DTACK_n && prev_d) order.push_back(0);
            if (CREG_GNT && !prev_g) order.push_back(1);
            prev_d = DTACK_n;
            prev_g = CREG_GNT;
            SBSELECT = DTACK_n;
            CREG_REQ = !CREG_GNT;
        end
        chk("alt grants", order.size(), 6);
        for (int i = 0; i < order.size(); i++) chk("alt order", order[i], i % 2);
        SBSELECT = 1'b0; CREG_REQ = 1'b0;
        step(); step(); step(); step(); step(); step();

        // CREG grant timeout: released at cycle 201, re-granted after arbitration.
        do_reset();
        CREG_REQ = 1'b1;
        gnt_cnt = 0; gnt_gap = -1;
        for (int c = 1; c <= 205; c++) begin
            step();
            if (CREG_GNT) gnt_cnt++;
            else if (gnt_gap < 0 && gnt_cnt > 0) gnt_gap = c;
        end
        chk("gtmo gnt_cnt", gnt_cnt, 204);
        chk("gtmo gap", gnt_gap, 201);
        chk("gtmo TMO", TMO, 1);
        CREG_REQ = 1'b0;
        step(); step();

        // Bus timeout with select held 300 cycles.
        do_reset();
        run_bus(9'h005, 0, 1, 300, 3);
        chk("tmo dtack_first", s_dtack_first, 4);
        chk("tmo dtack_cnt", s_dtack_cnt, 200);
        chk("tmo busy_cnt", s_busy_cnt, 203);
        chk("tmo TMO", TMO, 1);
        run_bus(9'h005, 0, 1, 6, 3);
        chk("tmo rearm strb_first", s_strb_first, 2);
        chk("tmo sticky", TMO, 1);

        // Reset during the first strobe cycle.
        A = 9'h005; SBREAD_n = 1'b0; DTACK_REQ_n = 1'b0; SBSELECT = 1'b1;
        step(); step();
        chk("rstmid pre STRB_n", STRB_n, 0);
        RESET_n = 1'b0;
        step();
        chk("rstmid STRB_n", STRB_n, 1);
        chk("rstmid BUSY", BUSY, 0);
        chk("rstmid TMO", TMO, 0);
        RESET_n = 1'b1; SBSELECT = 1'b0;
        step(); step();

        // Abort: select dropped during the first strobe cycle of a read.
        run_bus(9'h005, 1, 1, 2, 8);
        chk("abort strb_cnt", s_strb_cnt, 1);
        chk("abort dtack_cnt", s_dtack_cnt, 0);
        chk("abort rdl_cnt", s_rdl_cnt, 0);
        chk("abort busy_cnt", s_busy_cnt, 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
